// File: rtl/alu_issue_stage_if.sv
// Issue-stage bundle: upstream instruction/operand handshake, writeback forward, flush and ALU-side outputs.
// The stage sits on the slave modport; the environment driving it uses master.
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [3:0]  alu_func;
  logic [4:0]  rd_addr;
  logic        rd_write;
  logic        illegal_op;

  modport master (
    output in_valid, instruction, pc, rs1_data, rs2_data,
    output fwd_valid, fwd_addr, fwd_data, flush, out_ready,
    input  in_ready, out_valid, lhs, rhs, alu_func, rd_addr, rd_write, illegal_op
  );

  modport slave (
    input  in_valid, instruction, pc, rs1_data, rs2_data,
    input  fwd_valid, fwd_addr, fwd_data, flush, out_ready,
    output in_ready, out_valid, lhs, rhs, alu_func, rd_addr, rd_write, illegal_op
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Decodes RV32I OP/OP-IMM/LUI/AUIPC into registered ALU operands and function code.
// Latency: one cycle from accepted input to out_valid.
// Backpressure: holds its output while out_valid & !out_ready; in_ready = !out_valid | out_ready.
module alu_issue_stage #(
  parameter bit FWD_EN = 1'b1
) (
  input logic           clk,
  input logic           rst,
  alu_issue_stage_if.slave bus
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [3:0]  func;
    logic [4:0]  rd_addr;
    logic        rd_write;
    logic        illegal_op;
  } issue_t;

  issue_t      dec;
  issue_t      held;
  logic        out_valid_q;
  logic        load;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        f7b5;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i;
  logic [31:0] imm_u;

  assign opcode   = bus.instruction[6:0];
  assign f3       = bus.instruction[14:12];
  assign f7b5     = bus.instruction[30];
  assign rs1_addr = bus.instruction[19:15];
  assign rs2_addr = bus.instruction[24:20];
  assign imm_i    = {{20{bus.instruction[31]}}, bus.instruction[31:20]};
  assign imm_u    = {bus.instruction[31:12], 12'd0};

  // x0 always reads zero, even if a writeback targets it.
  function automatic logic [31:0] pick_operand(input logic [4:0] addr, input logic [31:0] rf_val);
    if (addr == 5'd0) begin
      return 32'd0;
    end else if (FWD_EN && bus.fwd_valid && (bus.fwd_addr == addr)) begin
      return bus.fwd_data;
    end
    return rf_val;
  endfunction

  assign rs1_val = pick_operand(rs1_addr, bus.rs1_data);
  assign rs2_val = pick_operand(rs2_addr, bus.rs2_data);

  always_comb begin
    dec         = '0;
    dec.rd_addr = bus.instruction[11:7];
    case (opcode)
      OPC_OP: begin
        dec.lhs  = rs1_val;
        dec.rhs  = rs2_val;
        dec.func = {f7b5 & ((f3 == 3'b000) | (f3 == 3'b101)), f3};
      end
      OPC_OPIMM: begin
        dec.lhs  = rs1_val;
        dec.rhs  = ((f3 == 3'b001) || (f3 == 3'b101)) ? {27'd0, rs2_addr} : imm_i;
        dec.func = {(f3 == 3'b101) ? f7b5 : 1'b0, f3};
      end
      OPC_LUI: begin
        dec.rhs = imm_u;
      end
      OPC_AUIPC: begin
        dec.lhs = bus.pc;
        dec.rhs = imm_u;
      end
      default: begin
        dec.illegal_op = 1'b1;
      end
    endcase
    dec.rd_write = !dec.illegal_op && (dec.rd_addr != 5'd0);
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      held        <= '0;
    end else begin
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (load) begin
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      // A flushed input is dropped outright, so it never reaches the register.
      if (load && !bus.flush) begin
        held <= dec;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.lhs        = held.lhs;
  assign bus.rhs        = held.rhs;
  assign bus.alu_func   = held.func;
  assign bus.rd_addr    = held.rd_addr;
  assign bus.rd_write   = held.rd_write;
  assign bus.illegal_op = held.illegal_op;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus stall, flush and reset sequences.
module tb_alu_issue_stage;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage #(.FWD_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        fv;
    logic [4:0]  fa;
    logic [31:0] fd;
    logic [31:0] e_lhs;
    logic [31:0] e_rhs;
    logic [3:0]  e_func;
    logic [4:0]  e_rd;
    logic        e_rdw;
    logic        e_ill;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.instruction = v.instr;
    bus.pc          = v.pc;
    bus.rs1_data    = v.rs1;
    bus.rs2_data    = v.rs2;
    bus.fwd_valid   = v.fv;
    bus.fwd_addr    = v.fa;
    bus.fwd_data    = v.fd;
  endtask

  task automatic check_vec(input vec_t v);
    check({v.name, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({v.name, ".lhs"}, bus.lhs, v.e_lhs);
    check({v.name, ".rhs"}, bus.rhs, v.e_rhs);
    check({v.name, ".func"}, {28'd0, bus.alu_func}, {28'd0, v.e_func});
    check({v.name, ".rd_addr"}, {27'd0, bus.rd_addr}, {27'd0, v.e_rd});
    check({v.name, ".rd_write"}, {31'd0, bus.rd_write}, {31'd0, v.e_rdw});
    check({v.name, ".illegal"}, {31'd0, bus.illegal_op}, {31'd0, v.e_ill});
  endtask

  initial begin
    //          name          instr         pc          rs1           rs2          fv    fa     fd            lhs           rhs           func     rd     rdw   ill
    vecs[0]  = '{"add",       32'h002081B3, 32'h40,     32'd5,        32'd7,       1'b0, 5'd0, 32'h0,        32'd5,        32'd7,        4'b0000, 5'd3,  1'b1, 1'b0};
    vecs[1]  = '{"srai",      32'h4030D213, 32'h40,     32'h80000000, 32'hDEAD,    1'b0, 5'd0, 32'h0,        32'h80000000, 32'd3,        4'b1101, 5'd4,  1'b1, 1'b0};
    vecs[2]  = '{"sub_fwd1",  32'h402082B3, 32'h40,     32'h99,       32'd4,       1'b1, 5'd1, 32'h10,       32'h10,       32'd4,        4'b1000, 5'd5,  1'b1, 1'b0};
    vecs[3]  = '{"sub_fwd0",  32'h402082B3, 32'h40,     32'd9,        32'd4,       1'b1, 5'd0, 32'h10,       32'd9,        32'd4,        4'b1000, 5'd5,  1'b1, 1'b0};
    vecs[4]  = '{"sub_fwd2",  32'h402082B3, 32'h40,     32'd9,        32'd4,       1'b1, 5'd2, 32'h20,       32'd9,        32'h20,       4'b1000, 5'd5,  1'b1, 1'b0};
    vecs[5]  = '{"auipc",     32'h12345317, 32'h100,    32'h77,       32'h88,      1'b0, 5'd0, 32'h0,        32'h100,      32'h12345000, 4'b0000, 5'd6,  1'b1, 1'b0};
    vecs[6]  = '{"lui",       32'hABCDE3B7, 32'h100,    32'h77,       32'h88,      1'b0, 5'd0, 32'h0,        32'h0,        32'hABCDE000, 4'b0000, 5'd7,  1'b1, 1'b0};
    vecs[7]  = '{"illegal",   32'h0000A403, 32'h40,     32'd5,        32'd7,       1'b0, 5'd0, 32'h0,        32'h0,        32'h0,        4'b0000, 5'd8,  1'b0, 1'b1};
    vecs[8]  = '{"addi_x0",   32'hFFF00493, 32'h40,     32'h55,       32'h0,       1'b1, 5'd0, 32'h77,       32'h0,        32'hFFFFFFFF, 4'b0000, 5'd9,  1'b1, 1'b0};
    vecs[9]  = '{"slli",      32'h00511513, 32'h40,     32'h1234,     32'h0,       1'b0, 5'd0, 32'h0,        32'h1234,     32'd5,        4'b0001, 5'd10, 1'b1, 1'b0};
    vecs[10] = '{"addi_b30",  32'h40008593, 32'h40,     32'd3,        32'h0,       1'b0, 5'd0, 32'h0,        32'd3,        32'h400,      4'b0000, 5'd11, 1'b1, 1'b0};
    vecs[11] = '{"xor_rd0",   32'h0020C033, 32'h40,     32'hF0,       32'h0F,      1'b0, 5'd0, 32'h0,        32'hF0,       32'h0F,       4'b0100, 5'd0,  1'b0, 1'b0};
    vecs[12] = '{"sra",       32'h4020D633, 32'h40,     32'd1,        32'd2,       1'b0, 5'd0, 32'h0,        32'd1,        32'd2,        4'b1101, 5'd12, 1'b1, 1'b0};
    vecs[13] = '{"or_b30",    32'h4020E6B3, 32'h40,     32'd1,        32'd2,       1'b0, 5'd0, 32'h0,        32'd1,        32'd2,        4'b0110, 5'd13, 1'b1, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    drive(vecs[0]);
    step();
    step();
    check("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset.lhs", bus.lhs, 32'd0);
    rst = 1'b0;

    // Back-to-back issue with the ALU always ready.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      step();
      check_vec(vecs[i]);
    end
    bus.in_valid = 1'b0;
    step();
    check("drain.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Stall three cycles with a new instruction waiting, then flush it away.
    drive(vecs[0]);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    step();
    check_vec(vecs[0]);
    drive(vecs[1]);
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall.in_ready", {31'd0, bus.in_ready}, 32'd0);
      check_vec(vecs[0]);
    end
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    check("flush.out_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    step();
    check("flush.no_retry", {31'd0, bus.out_valid}, 32'd0);

    // Reset arriving while the output is stalled.
    drive(vecs[5]);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    step();
    check_vec(vecs[5]);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    step();
    rst = 1'b0;
    check("rst_stall.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_stall.in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_stall.lhs", bus.lhs, 32'd0);
    check("rst_stall.rhs", bus.rhs, 32'd0);
    check("rst_stall.func", {28'd0, bus.alu_func}, 32'd0);
    check("rst_stall.rd_addr", {27'd0, bus.rd_addr}, 32'd0);
    check("rst_stall.rd_write", {31'd0, bus.rd_write}, 32'd0);
    check("rst_stall.illegal", {31'd0, bus.illegal_op}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
